// File: rtl/display_request_scheduler.sv
// display_request_scheduler: round-robin sharing of one 4-digit seven-segment
// display between NUM_SRC requesters. The winner's 10-bit two's-complement
// value is clamped to +/-255 and held on screen for HOLD_CYCLES before the
// next arbitration.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req[NUM_SRC]          per-source request level
//   value_in[10*NUM_SRC]  source i value at bits [10i+9:10i]
//   ack[NUM_SRC]          one-cycle one-hot pulse when a source's value is latched
//   display_value[10]     clamped value to the binary-to-7-segment converter
//   display_src[SRC_W]    index of the source currently shown
//   display_valid         high once any value has been latched since reset
//   busy                  high while a grant is being held
//
// Optional build macro SEG_PREEMPT_EN: a source 0 request preempts a hold
// owned by any other source.
module display_request_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int SRC_W       = 2,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [10*NUM_SRC-1:0]  value_in,
  output logic [NUM_SRC-1:0]     ack,
  output logic [9:0]             display_value,
  output logic [SRC_W-1:0]       display_src,
  output logic                   display_valid,
  output logic                   busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [9:0]           display_value_q, display_value_d;
  logic [SRC_W-1:0]     display_src_q, display_src_d;
  logic                 display_valid_q, display_valid_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;

  logic                 sel_vld;
  logic [SRC_W-1:0]     rr_sel;
  logic [SRC_W-1:0]     sel;
  logic [9:0]           sel_value;
  logic [9:0]           clamped;
  logic                 grant_cond;
  logic                 grant;
  logic                 preempt;

  // Round-robin pick: scan offsets from last_grant+NUM_SRC down to
  // last_grant+1 so the smallest offset (closest after last_grant) wins.
  always_comb begin
    sel_vld = 1'b0;
    rr_sel  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (req[idx]) begin
        sel_vld = 1'b1;
        rr_sel  = SRC_W'(idx);
      end
    end
  end

`ifdef SEG_PREEMPT_EN
  // Source 0 jumps the queue, but never preempts itself.
  assign preempt = (state_q == HOLD) && (display_src_q != '0) && req[0];
`else
  assign preempt = 1'b0;
`endif

  assign sel        = preempt ? '0 : rr_sel;
  assign grant_cond = (state_q == IDLE) || (counter_q == '0) || preempt;
  assign grant      = grant_cond && sel_vld;

  // Saturate to the converter's 8-bit magnitude range.
  always_comb begin
    sel_value = value_in[10*sel +: 10];
    if ($signed(sel_value) > $signed(10'sd255)) begin
      clamped = 10'h0FF;
    end else if ($signed(sel_value) < -$signed(10'sd255)) begin
      clamped = 10'h301;
    end else begin
      clamped = sel_value;
    end
  end

  always_comb begin
    state_d         = state_q;
    counter_d       = counter_q;
    last_grant_d    = last_grant_q;
    display_value_d = display_value_q;
    display_src_d   = display_src_q;
    display_valid_d = display_valid_q;
    ack_d           = '0;
    if (grant) begin
      state_d         = HOLD;
      counter_d       = CNT_W'(HOLD_CYCLES - 1);
      last_grant_d    = sel;
      display_value_d = clamped;
      display_src_d   = sel;
      display_valid_d = 1'b1;
      ack_d[sel]      = 1'b1;
    end else if (state_q == HOLD) begin
      if (counter_q != '0) begin
        counter_d = counter_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      counter_q       <= '0;
      last_grant_q    <= SRC_W'(NUM_SRC - 1);
      display_value_q <= '0;
      display_src_q   <= '0;
      display_valid_q <= 1'b0;
      ack_q           <= '0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      last_grant_q    <= last_grant_d;
      display_value_q <= display_value_d;
      display_src_q   <= display_src_d;
      display_valid_q <= display_valid_d;
      ack_q           <= ack_d;
    end
  end

  assign ack           = ack_q;
  assign display_value = display_value_q;
  assign display_src   = display_src_q;
  assign display_valid = display_valid_q;
  assign busy          = (state_q == HOLD);

endmodule

// File: tb/tb_display_request_scheduler.sv
// Testbench for display_request_scheduler with HOLD_CYCLES=4.
// Expected grants are queued as stimulus is driven and compared when ack pulses.
module tb_display_request_scheduler;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int HOLD    = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_SRC-1:0]    req = '0;
  logic [10*NUM_SRC-1:0] value_in = '0;
  logic [NUM_SRC-1:0]    ack;
  logic [9:0]            display_value;
  logic [SRC_W-1:0]      display_src;
  logic                  display_valid;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [9:0]       val;
  } exp_t;

  exp_t exp_q[$];

  display_request_scheduler #(
    .NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .HOLD_CYCLES(HOLD), .CNT_W(3)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .value_in(value_in),
    .ack(ack), .display_value(display_value), .display_src(display_src),
    .display_valid(display_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] clamp_ref(input logic [9:0] v);
    int s;
    logic [9:0] r;
    s = v[9] ? int'(v) - 1024 : int'(v);
    if (s > 255)  s = 255;
    if (s < -255) s = -255;
    r = s[9:0];
    return r;
  endfunction

  // Scoreboard: every ack pulse must match the next queued grant.
  always @(negedge clock) begin
    if (!reset && ack != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {28'd0, ack}, 32'd0);
      end else begin
        exp_t e;
        logic [NUM_SRC-1:0] oh;
        e  = exp_q.pop_front();
        oh = '0;
        oh[e.src] = 1'b1;
        check("sb_ack",   {28'd0, ack}, {28'd0, oh});
        check("sb_src",   {30'd0, display_src}, {30'd0, e.src});
        check("sb_value", {22'd0, display_value}, {22'd0, e.val});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_val(input int i, input logic [9:0] v);
    value_in[10*i +: 10] = v;
  endtask

  task automatic expect_grant(input int s, input logic [9:0] raw);
    exp_t e;
    e.src = SRC_W'(s);
    e.val = clamp_ref(raw);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = '0;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    req = '0;
    for (int i = 0; i < HOLD + 1; i++) tick();
    check(tag, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, exp_q.size(), 32'd0);
  endtask

  logic [9:0] clamp_vals [6];
  int grant_at;

  initial begin
    // Reset state.
    #3;
    check("rst_ack",   {28'd0, ack}, 32'd0);
    check("rst_value", {22'd0, display_value}, 32'd0);
    check("rst_valid", {31'd0, display_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    #4;
    reset = 1'b0;
    tick();

    // Single request, full hold then IDLE with value retained.
    set_val(0, 10'd123);
    req = 4'b0001;
    expect_grant(0, 10'd123);
    tick();
    req = '0;
    check("s1_ack",   {28'd0, ack}, 32'd1);
    check("s1_valid", {31'd0, display_valid}, 32'd1);
    check("s1_busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check("s1_ack_low", {28'd0, ack}, 32'd0);
      check("s1_busy",    {31'd0, busy}, 32'd1);
    end
    tick();
    check("s1_idle",  {31'd0, busy}, 32'd0);
    check("s1_keep",  {22'd0, display_value}, 32'd123);

    // Full contention: 0,1,2,3,0 every HOLD cycles.
    do_reset();
    for (int i = 0; i < 4; i++) set_val(i, 10'(i + 1));
    for (int i = 0; i < 5; i++) expect_grant(i % 4, 10'((i % 4) + 1));
    req = 4'b1111;
    for (int c = 0; c < 4 * HOLD + 1; c++) begin
      tick();
      check("rr_busy", {31'd0, busy}, 32'd1);
      check("rr_ack_timing", {31'd0, (ack != '0)}, {31'd0, (c % HOLD == 0)});
    end
    wait_idle("rr_idle");

    // Clamp boundaries.
    clamp_vals[0] = 10'd300;
    clamp_vals[1] = 10'h200;
    clamp_vals[2] = 10'h301;
    clamp_vals[3] = 10'h3FF;
    clamp_vals[4] = 10'd256;
    clamp_vals[5] = 10'h300;
    foreach (clamp_vals[k]) begin
      set_val(0, clamp_vals[k]);
      req = 4'b0001;
      expect_grant(0, clamp_vals[k]);
      tick();
      req = '0;
      check("clamp_direct", {22'd0, display_value}, {22'd0, clamp_ref(clamp_vals[k])});
      wait_idle("clamp_idle");
    end

    // Withdrawn request during hold: no ack for source 1.
    set_val(0, 10'd7);
    req = 4'b0001;
    expect_grant(0, 10'd7);
    tick();
    req = 4'b0010;
    tick();
    tick();
    req = '0;
    tick();
    check("wd_busy", {31'd0, busy}, 32'd1);
    tick();
    check("wd_idle", {31'd0, busy}, 32'd0);
    check("wd_src",  {30'd0, display_src}, 32'd0);
    check("wd_q",    exp_q.size(), 32'd0);

    // Asynchronous reset mid-hold, then source 1 wins first.
    set_val(0, 10'd9);
    req = 4'b0001;
    expect_grant(0, 10'd9);
    tick();
    req = '0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("ar_ack",   {28'd0, ack}, 32'd0);
    check("ar_value", {22'd0, display_value}, 32'd0);
    check("ar_src",   {30'd0, display_src}, 32'd0);
    check("ar_valid", {31'd0, display_valid}, 32'd0);
    check("ar_busy",  {31'd0, busy}, 32'd0);
    set_val(1, 10'd55);
    set_val(3, 10'd66);
    req = 4'b1010;
    reset = 1'b0;
    expect_grant(1, 10'd55);
    tick();
    req = '0;
    check("ar_first", {30'd0, display_src}, 32'd1);
    wait_idle("ar_idle");

    // Source 0 request during a source 2 hold.
    do_reset();
    set_val(2, 10'd20);
    req = 4'b0100;
    expect_grant(2, 10'd20);
    tick();
    set_val(0, 10'd11);
    req = 4'b0001;
    expect_grant(0, 10'd11);
`ifdef SEG_PREEMPT_EN
    grant_at = 1;
`else
    grant_at = HOLD;
`endif
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      check("pre_ack0", {31'd0, ack[0]}, {31'd0, (i == grant_at)});
      if (i == grant_at) req = '0;
    end
    wait_idle("pre_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
